// File: rtl/adder_bist_pkg.sv
// Shared types and constants for the ripple-adder BIST engine.
package adder_bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int MAX_DUT_LAT = 3;

  // Vector index is {X, Y, Cin}.
  function automatic int vec_w(input int width);
    return 2 * width + 1;
  endfunction

endpackage

// File: rtl/adder_bist_if.sv
// Operand/response bus between the BIST engine and the adder under test.
interface adder_bist_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] x_o;
  logic [WIDTH-1:0] y_o;
  logic             cin_o;
  logic [WIDTH-1:0] sum_i;
  logic             cout_i;

  modport master (output x_o, y_o, cin_o, input sum_i, cout_i);
  modport slave  (input x_o, y_o, cin_o, output sum_i, cout_i);
endinterface

// File: rtl/adder_bist_scoreboard.sv
// Delay line of applied vectors, golden compare, saturating error count and first-fail capture.
module adder_bist_scoreboard
  import adder_bist_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int DUT_LAT = 0,
  parameter int ERR_W   = 16,
  localparam int VW     = vec_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [VW-1:0]    in_vec,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output logic [ERR_W-1:0] err_count,
  output logic [VW-1:0]    fail_vec,
  output logic             fail_valid
);

  typedef struct packed {
    logic             valid;
    logic [VW-1:0]    vec;
    logic [WIDTH:0]   gold;
  } entry_t;

  function automatic logic [WIDTH:0] golden(input logic [VW-1:0] v);
    return {1'b0, v[VW-1 -: WIDTH]} + {1'b0, v[WIDTH:1]} + {{WIDTH{1'b0}}, v[0]};
  endfunction

  entry_t line [DUT_LAT+1];
  entry_t tail;
  logic   mismatch;

  // Stage 0 loads alongside the operand register, so the tail lines up with the adder's latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= DUT_LAT; i++) line[i] <= '0;
    end else begin
      line[0] <= {in_valid, in_vec, golden(in_vec)};
      for (int i = 1; i <= DUT_LAT; i++) line[i] <= line[i-1];
    end
  end

  assign tail     = line[DUT_LAT];
  assign mismatch = tail.valid && ({cout, sum} != tail.gold);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count  <= '0;
      fail_vec   <= '0;
      fail_valid <= 1'b0;
    end else if (clear) begin
      err_count  <= '0;
      fail_vec   <= '0;
      fail_valid <= 1'b0;
    end else if (mismatch) begin
      if (err_count != '1) err_count <= err_count + ERR_W'(1);
      if (!fail_valid) begin
        fail_vec   <= tail.vec;
        fail_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_bist.sv
// BIST top: sweep FSM and vector counter driving the adder under test.
module adder_bist
  import adder_bist_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int DUT_LAT = 0,
  parameter int ERR_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  adder_bist_if.master       adder,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count,
  output logic [2*WIDTH:0]   fail_vec,
  output logic               fail_valid
);

  localparam int VW = vec_w(WIDTH);
  localparam int DW = $clog2(MAX_DUT_LAT + 1);

  state_t        state, state_nx;
  logic [VW-1:0] vec, vec_nx;
  logic [VW-1:0] drive;
  logic [DW-1:0] drain_cnt, drain_nx;
  logic          busy_nx;
  logic          armed;
  logic          clear;

  always_comb begin
    state_nx = state;
    vec_nx   = vec;
    drain_nx = drain_cnt;
    clear    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start && armed) begin
          state_nx = RUN;
          vec_nx   = '0;
          clear    = 1'b1;
        end
      end
      RUN: begin
        vec_nx = vec + VW'(1);
        if (&vec) begin
          state_nx = DRAIN;
          drain_nx = '0;
        end
      end
      DRAIN: begin
        if (drain_cnt == DW'(DUT_LAT)) state_nx = DONE;
        else                           drain_nx = drain_cnt + DW'(1);
      end
      default: state_nx = IDLE;
    endcase
    // busy follows the operand register: rises one edge after RUN begins, falls as DONE is entered
    busy_nx = (state == RUN || state == DRAIN) && (state_nx == RUN || state_nx == DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vec       <= '0;
      drain_cnt <= '0;
      drive     <= '0;
      busy      <= 1'b0;
      armed     <= 1'b0;
    end else begin
      state     <= state_nx;
      vec       <= vec_nx;
      drain_cnt <= drain_nx;
      drive     <= (state == RUN) ? vec : '0;
      busy      <= busy_nx;
      armed     <= 1'b1;
    end
  end

  assign adder.x_o   = drive[VW-1 -: WIDTH];
  assign adder.y_o   = drive[WIDTH:1];
  assign adder.cin_o = drive[0];

  assign done = (state == DONE);
  assign pass = done && (err_count == '0);

  adder_bist_scoreboard #(
    .WIDTH   (WIDTH),
    .DUT_LAT (DUT_LAT),
    .ERR_W   (ERR_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (state == RUN),
    .in_vec     (vec),
    .sum        (adder.sum_i),
    .cout       (adder.cout_i),
    .err_count  (err_count),
    .fail_vec   (fail_vec),
    .fail_valid (fail_valid)
  );

endmodule

// File: tb/tb_adder_bist.sv
// Self-checking bench for adder_bist against several good and faulty adder models.
module tb_adder_bist;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] st = '0;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  logic [6:0]  busy, done, pass, fvld;
  logic [15:0] err0, err1, err2, err3, err4;
  logic [4:0]  fv0, fv1, fv2, fv3, fv4;
  logic [3:0]  err5;
  logic [8:0]  fv5;
  logic [4:0]  err6;
  logic [6:0]  fv6;

  adder_bist_if #(.WIDTH(2)) b0 ();
  adder_bist_if #(.WIDTH(2)) b1 ();
  adder_bist_if #(.WIDTH(2)) b2 ();
  adder_bist_if #(.WIDTH(2)) b3 ();
  adder_bist_if #(.WIDTH(2)) b4 ();
  adder_bist_if #(.WIDTH(4)) b5 ();
  adder_bist_if #(.WIDTH(3)) b6 ();

  // Adder models: correct, 2-stage registered, sum[0] stuck, cout inverted, all wrong, random faults.
  logic [2:0] s0, s3, s4;
  logic [4:0] s5;
  logic [3:0] s6;
  logic [2:0] r1a = '0, r1b = '0, r2a = '0, r2b = '0;
  logic [3:0] r6 = '0;
  logic [3:0] flip6 = '0;
  bit         bad6 [128];

  assign s0 = b0.x_o + b0.y_o + b0.cin_o;
  assign s3 = b3.x_o + b3.y_o + b3.cin_o;
  assign s4 = b4.x_o + b4.y_o + b4.cin_o;
  assign s5 = b5.x_o + b5.y_o + b5.cin_o;
  assign s6 = b6.x_o + b6.y_o + b6.cin_o;

  always @(posedge clk) begin
    r1a <= b1.x_o + b1.y_o + b1.cin_o;
    r1b <= r1a;
    r2a <= b2.x_o + b2.y_o + b2.cin_o;
    r2b <= r2a;
    r6  <= s6 ^ (bad6[{b6.x_o, b6.y_o, b6.cin_o}] ? flip6 : 4'd0);
  end

  assign {b0.cout_i, b0.sum_i} = s0;
  assign {b1.cout_i, b1.sum_i} = r1b;
  assign {b2.cout_i, b2.sum_i} = r2b;
  assign b3.cout_i = s3[2];
  assign b3.sum_i  = s3[1:0] & 2'b10;
  assign b4.cout_i = ~s4[2];
  assign b4.sum_i  = s4[1:0];
  assign b5.cout_i = ~s5[4];
  assign b5.sum_i  = ~s5[3:0];
  assign {b6.cout_i, b6.sum_i} = r6;

  adder_bist #(.WIDTH(2), .DUT_LAT(0)) u0 (.clk(clk), .rst_n(rst_n), .start(st[0]), .adder(b0),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err0), .fail_vec(fv0), .fail_valid(fvld[0]));
  adder_bist #(.WIDTH(2), .DUT_LAT(2)) u1 (.clk(clk), .rst_n(rst_n), .start(st[1]), .adder(b1),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err1), .fail_vec(fv1), .fail_valid(fvld[1]));
  adder_bist #(.WIDTH(2), .DUT_LAT(1)) u2 (.clk(clk), .rst_n(rst_n), .start(st[2]), .adder(b2),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(err2), .fail_vec(fv2), .fail_valid(fvld[2]));
  adder_bist #(.WIDTH(2), .DUT_LAT(0)) u3 (.clk(clk), .rst_n(rst_n), .start(st[3]), .adder(b3),
    .busy(busy[3]), .done(done[3]), .pass(pass[3]), .err_count(err3), .fail_vec(fv3), .fail_valid(fvld[3]));
  adder_bist #(.WIDTH(2), .DUT_LAT(0)) u4 (.clk(clk), .rst_n(rst_n), .start(st[4]), .adder(b4),
    .busy(busy[4]), .done(done[4]), .pass(pass[4]), .err_count(err4), .fail_vec(fv4), .fail_valid(fvld[4]));
  adder_bist #(.WIDTH(4), .DUT_LAT(0), .ERR_W(4)) u5 (.clk(clk), .rst_n(rst_n), .start(st[5]), .adder(b5),
    .busy(busy[5]), .done(done[5]), .pass(pass[5]), .err_count(err5), .fail_vec(fv5), .fail_valid(fvld[5]));
  adder_bist #(.WIDTH(3), .DUT_LAT(1), .ERR_W(5)) u6 (.clk(clk), .rst_n(rst_n), .start(st[6]), .adder(b6),
    .busy(busy[6]), .done(done[6]), .pass(pass[6]), .err_count(err6), .fail_vec(fv6), .fail_valid(fvld[6]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle; returns at the sample point just after the edge that took it.
  task automatic run_start(input int idx);
    @(negedge clk);
    st[idx] = 1'b1;
    @(negedge clk);
    st[idx] = 1'b0;
  endtask

  task automatic wait_done(input int idx, input int limit, output int at);
    at = -1;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (done[idx] === 1'b1) begin
        at = n;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int port_bad, busy_n, d0, d1, exp_vec, cnt, first, exp_err;

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_fvld", 32'(fvld), 0);
    chk("rst_err", err0, 0);
    chk("rst_port", {b0.x_o, b0.y_o, b0.cin_o}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Parallel sweep of the five WIDTH=2 engines; sample i follows edge k+i.
    st[4:0] = '1;
    @(negedge clk);
    st = '0;
    chk("busy_at_k", busy[0], 0);
    port_bad = 0; busy_n = 0; d0 = -1; d1 = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      exp_vec = (i <= 32) ? i - 1 : 0;
      if ({b0.x_o, b0.y_o, b0.cin_o} !== 5'(exp_vec)) port_bad++;
      if (busy[0] === 1'b1) busy_n++;
      if (done[0] === 1'b1 && d0 < 0) d0 = i;
      if (done[1] === 1'b1 && d1 < 0) d1 = i;
    end
    chk("port_sequence", port_bad, 0);
    chk("busy_length", busy_n, 32 + 0);
    chk("done_edge_lat0", d0, 32 + 0 + 1);
    chk("done_edge_lat2", d1, 32 + 2 + 1);
    chk("good_pass", pass[0], 1);
    chk("good_err", err0, 0);
    chk("good_fvld", fvld[0], 0);
    chk("lat2_pass", pass[1], 1);
    chk("lat_mismatch_pass", pass[2], 0);
    chk("stuck_err", err3, 16);
    chk("stuck_fv", fv3, 5'b00001);
    chk("stuck_pass", pass[3], 0);
    chk("cout_err", err4, 32);
    chk("cout_fv", fv4, 0);
    chk("cout_fvld", fvld[4], 1);

    // Asynchronous reset mid-sweep.
    st[0] = 1'b1; st[4] = 1'b1;
    @(negedge clk);
    st = '0;
    repeat ($urandom_range(3, 20)) @(negedge clk);
    chk("midrun_busy", busy[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", busy[0], 0);
    chk("async_port", {b0.x_o, b0.y_o, b0.cin_o}, 0);
    chk("async_err", err4, 0);
    chk("async_fvld", fvld[4], 0);
    chk("async_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    @(negedge clk);
    chk("start_at_release_ignored", busy[0], 0);
    run_start(0);
    wait_done(0, 60, d0);
    chk("resweep_done", d0, 33);
    chk("resweep_pass", pass[0], 1);
    chk("resweep_err", err0, 0);

    // Saturation, ignored start while busy, restart from DONE.
    run_start(5);
    repeat (4) @(negedge clk);
    st[5] = 1'b1;
    @(negedge clk);
    st[5] = 1'b0;
    chk("busy_during_restart", busy[5], 1);
    wait_done(5, 700, d0);
    chk("sat_done_edge", (d0 < 0) ? d0 : d0 + 5, 512 + 1);
    chk("sat_err", err5, 15);
    chk("sat_pass", pass[5], 0);
    chk("sat_fvld", fvld[5], 1);
    chk("sat_fv", fv5, 0);
    run_start(5);
    chk("restart_done_low", done[5], 0);
    chk("restart_err_clr", err5, 0);
    chk("restart_fvld_clr", fvld[5], 0);
    wait_done(5, 700, d0);
    chk("restart_done_edge", d0, 513);
    chk("restart_err", err5, 15);

    // Random fault maps on a WIDTH=3, latency-1 adder against a counting model.
    for (int r = 0; r < 3; r++) begin
      flip6 = 4'($urandom_range(1, 15));
      cnt = 0;
      first = -1;
      for (int v = 0; v < 128; v++) begin
        bad6[v] = (r == 1) ? 1'b0 : ($urandom_range(0, (r == 0) ? 3 : 31) == 0);
        if (bad6[v]) begin
          cnt++;
          if (first < 0) first = v;
        end
      end
      exp_err = (cnt > 31) ? 31 : cnt;
      run_start(6);
      wait_done(6, 300, d0);
      chk("rand_done_edge", d0, 128 + 1 + 1);
      chk("rand_err", err6, exp_err);
      chk("rand_fvld", fvld[6], (cnt > 0) ? 1 : 0);
      chk("rand_fv", fv6, (first < 0) ? 0 : first);
      chk("rand_pass", pass[6], (cnt == 0) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
